// File: rtl/if_pc_ctrl.sv
// if_pc_ctrl: IF-stage program counter sequencer with branch/flush redirect,
// deferred branch redirect while memory is busy, and continuous fetch request.
module if_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        if_ack,
  output logic        ce,
  output logic        if_req,
  output logic [31:0] pc,
  output logic        inst_valid
);
  typedef enum logic {BOOT, FETCH} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_pend_pc, w_pc_nxt, w_pend_pc_nxt;
  logic        r_pend_vld, w_pend_vld_nxt, w_fetch;
  assign w_fetch    = r_state == FETCH;
  assign ce         = w_fetch;
  assign if_req     = w_fetch;
  assign pc         = r_pc;
  assign inst_valid = w_fetch & if_ack & ~stall & ~r_pend_vld & ~flush & ~branch_flag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end
  // A branch without an ack is parked until memory finishes the in-flight fetch
  always_comb begin
    w_state_nxt    = FETCH;
    w_pc_nxt       = r_pc;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_pc_nxt  = r_pend_pc;
    if (w_fetch) begin
      if (flush) begin
        w_pc_nxt       = new_pc & ~32'd3;
        w_pend_vld_nxt = 1'b0;
      end else if (branch_flag && if_ack) begin
        w_pc_nxt       = branch_target & ~32'd3;
        w_pend_vld_nxt = 1'b0;
      end else if (branch_flag) begin
        w_pend_pc_nxt  = branch_target & ~32'd3;
        w_pend_vld_nxt = 1'b1;
      end else if (r_pend_vld && if_ack) begin
        w_pc_nxt       = r_pend_pc;
        w_pend_vld_nxt = 1'b0;
      end else if (if_ack && !stall) begin
        w_pc_nxt       = r_pc + PC_INC;
      end
    end
  end
endmodule

// File: tb/tb_if_pc_ctrl.sv
// tb_if_pc_ctrl: directed vector table, reset/wrap corners and randomized
// traffic checked against a reference model of the fetch sequencer.
module tb_if_pc_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 1'b0, branch_flag = 1'b0, flush = 1'b0, if_ack = 1'b0;
  logic [31:0] branch_target = '0, new_pc = '0;
  logic        ce0, ce1, req0, req1, iv0, iv1;
  logic [31:0] pc0, pc1;
  int          n_pass = 0, n_tot = 0;

  localparam logic [31:0] RST1 = 32'hFFFF_FFF8;

  if_pc_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .new_pc(new_pc), .if_ack(if_ack),
    .ce(ce0), .if_req(req0), .pc(pc0), .inst_valid(iv0)
  );
  if_pc_ctrl #(.RESET_PC(RST1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .new_pc(new_pc), .if_ack(if_ack),
    .ce(ce1), .if_req(req1), .pc(pc1), .inst_valid(iv1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] np;
    logic        ack;
    logic [31:0] pc0, pc1;
    logic        iv, ce;
  } vec_t;
  vec_t tab[25];

  // Reference model: one boot cycle, a PC per instance and a redirect mailbox.
  logic        m_boot;
  logic [31:0] m_pc[2];
  logic [31:0] pend_q[$];

  function automatic vec_t mk(logic st, logic bf, logic [31:0] bt, logic fl, logic [31:0] np,
                              logic ack, logic [31:0] p0, logic [31:0] p1, logic iv, logic c);
    vec_t v;
    v.st = st; v.bf = bf; v.bt = bt; v.fl = fl; v.np = np; v.ack = ack;
    v.pc0 = p0; v.pc1 = p1; v.iv = iv; v.ce = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic st, input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np, input logic ack);
    stall = st; branch_flag = bf; branch_target = bt; flush = fl; new_pc = np; if_ack = ack;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_pc[0] = 32'd0; m_pc[1] = RST1; pend_q.delete();
  endtask

  task automatic model_chk();
    logic exp_iv;
    exp_iv = !m_boot && if_ack && !stall && pend_q.size() == 0 && !flush && !branch_flag;
    chk("m_pc0", pc0, m_pc[0]);
    chk("m_pc1", pc1, m_pc[1]);
    chk("m_ce0", {31'd0, ce0}, {31'd0, !m_boot});
    chk("m_req1", {31'd0, req1}, {31'd0, !m_boot});
    chk("m_iv0", {31'd0, iv0}, {31'd0, exp_iv});
    chk("m_iv1", {31'd0, iv1}, {31'd0, exp_iv});
  endtask

  task automatic model_step();
    if (m_boot) m_boot = 1'b0;
    else if (flush) begin
      m_pc[0] = new_pc & ~32'd3; m_pc[1] = m_pc[0]; pend_q.delete();
    end else if (branch_flag && if_ack) begin
      m_pc[0] = branch_target & ~32'd3; m_pc[1] = m_pc[0]; pend_q.delete();
    end else if (branch_flag) begin
      pend_q.delete(); pend_q.push_back(branch_target & ~32'd3);
    end else if (pend_q.size() != 0 && if_ack) begin
      m_pc[0] = pend_q.pop_front(); m_pc[1] = m_pc[0];
    end else if (if_ack && !stall) begin
      m_pc[0] += 32'd4; m_pc[1] += 32'd4;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_chk();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    tab[0]  = mk(0,0,0,0,0,1, 32'h0,  32'hFFFFFFF8, 0, 0);
    tab[1]  = mk(0,0,0,0,0,1, 32'h0,  32'hFFFFFFF8, 1, 1);
    tab[2]  = mk(0,0,0,0,0,1, 32'h4,  32'hFFFFFFFC, 1, 1);
    tab[3]  = mk(0,0,0,0,0,1, 32'h8,  32'h0,        1, 1);
    tab[4]  = mk(0,0,0,0,0,1, 32'hC,  32'h4,        1, 1);
    tab[5]  = mk(0,0,0,0,0,0, 32'h10, 32'h8,        0, 1);
    tab[6]  = mk(0,0,0,0,0,0, 32'h10, 32'h8,        0, 1);
    tab[7]  = mk(0,0,0,0,0,1, 32'h10, 32'h8,        1, 1);
    tab[8]  = mk(0,0,0,0,0,0, 32'h14, 32'hC,        0, 1);
    tab[9]  = mk(0,0,0,0,0,0, 32'h14, 32'hC,        0, 1);
    tab[10] = mk(0,0,0,0,0,1, 32'h14, 32'hC,        1, 1);
    tab[11] = mk(0,0,0,1,32'h40,0, 32'h18, 32'h10,  0, 1);
    tab[12] = mk(0,1,32'h103,0,0,1, 32'h40, 32'h40, 0, 1);
    tab[13] = mk(0,0,0,0,0,1, 32'h100, 32'h100,     1, 1);
    tab[14] = mk(0,1,32'h200,0,0,0, 32'h104, 32'h104, 0, 1);
    tab[15] = mk(0,0,0,0,0,0, 32'h104, 32'h104,     0, 1);
    tab[16] = mk(0,0,0,0,0,1, 32'h104, 32'h104,     0, 1);
    tab[17] = mk(0,0,0,0,0,1, 32'h200, 32'h200,     1, 1);
    tab[18] = mk(0,0,0,1,32'h80,0, 32'h204, 32'h204, 0, 1);
    tab[19] = mk(1,0,0,0,0,1, 32'h80, 32'h80,       0, 1);
    tab[20] = mk(1,0,0,0,0,1, 32'h80, 32'h80,       0, 1);
    tab[21] = mk(1,1,32'h300,1,32'hBFC00380,0, 32'h80, 32'h80, 0, 1);
    tab[22] = mk(1,0,0,0,0,1, 32'hBFC00380, 32'hBFC00380, 0, 1);
    tab[23] = mk(0,0,0,0,0,1, 32'hBFC00380, 32'hBFC00380, 1, 1);
    tab[24] = mk(0,0,0,0,0,0, 32'hBFC00384, 32'hBFC00384, 0, 1);

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive(tab[i].st, tab[i].bf, tab[i].bt, tab[i].fl, tab[i].np, tab[i].ack);
      @(negedge clk);
      model_chk();
      chk($sformatf("tab%0d_pc0", i), pc0, tab[i].pc0);
      chk($sformatf("tab%0d_pc1", i), pc1, tab[i].pc1);
      chk($sformatf("tab%0d_iv", i), {31'd0, iv0}, {31'd0, tab[i].iv});
      chk($sformatf("tab%0d_ce", i), {31'd0, ce0}, {31'd0, tab[i].ce});
      chk($sformatf("tab%0d_req", i), {31'd0, req0}, {31'd0, tab[i].ce});
      @(posedge clk);
      model_step();
      #1;
    end

    // Latest branch wins while a redirect is parked
    drive(0,1,32'h600,0,0,0); cyc();
    drive(0,1,32'h702,0,0,0); cyc();
    drive(0,0,0,0,0,1);       cyc();
    drive(0,0,0,0,0,0);       cyc();
    chk("latest_wins_pc", pc0, 32'h700);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0,3) == 0, $urandom_range(0,6) == 0, $urandom,
            $urandom_range(0,11) == 0, $urandom, $urandom_range(0,1) == 1);
      cyc();
    end

    // Async reset with a redirect parked: everything clears without a clock edge
    drive(0,1,32'h500,0,0,0); cyc();
    drive(0,0,0,0,0,1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc0", pc0, 32'h0);
    chk("arst_pc1", pc1, RST1);
    chk("arst_ce0", {31'd0, ce0}, 32'd0);
    chk("arst_req1", {31'd0, req1}, 32'd0);
    chk("arst_iv0", {31'd0, iv0}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) cyc();
    chk("post_rst_pc0", pc0, 32'h0C);
    chk("post_rst_pc1", pc1, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
